// File: rtl/serial_receiver.sv
// Single-wire serial receiver: start, DATA_BITS data bits (LSB first), parity, stop.
// Define SERIAL_RX_PARITY_CHECK_EN to build the parity comparison and drive parity_err.
module serial_receiver #(
   parameter int DATA_BITS    = 7,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] START_END = CW'((H > 0) ? H - 1 : 0);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 tick;
`ifdef SERIAL_RX_PARITY_CHECK_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   // START waits H edges for the mid-bit re-check; every later sample is one full bit apart
   assign tick = (cnt_q == ((state_q == START) ? START_END : BIT_END));

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // with H=0 the start re-check is this very sample
            if (!serial_in) state_d = (H == 0) ? DATA : START;
         end
         START: begin
            if (tick) state_d = serial_in ? IDLE : DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d[bit_q] = serial_in;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = PARITY;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
               par_d = serial_in;
`endif
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (serial_in) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_CHECK_EN
                  perr_d  = (^shift_q) ^ par_q;
`endif
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (serial_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_CHECK_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_CHECK_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
